// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the MIG user-port arbiter: command codes, FSM states
// and burst geometry.
package dram_arbiter_pkg;

  localparam int BEATS_PER_BURST = 2;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CMD   = 3'd1,
    ST_WR_CMD   = 3'd2,
    ST_WR_BEAT0 = 3'd3,
    ST_WR_BEAT1 = 3'd4,
    ST_ERROR    = 3'd5
  } arb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value, input logic [7:0] limit);
    sat_inc8 = (value >= limit) ? limit : value + 8'd1;
  endfunction

endpackage

// File: rtl/dram_arbiter_credit.sv
// Read-side bookkeeping: FIFO space reserved by accepted reads, beats still
// owed by the MIG, and detection of either count being driven below zero.
module dram_arbiter_credit
  import dram_arbiter_pkg::*;
#(
  parameter int RD_CREDITS = 32
) (
  input  logic       dram_clk,
  input  logic       reset_n,
  input  logic       rd_accept,
  input  logic       rd_beat_pop,
  input  logic       app_rd_data_valid,
  output logic [7:0] credit_avail,
  output logic       underflow_err
);

  localparam logic [7:0] CREDIT_MAX  = 8'(RD_CREDITS);
  localparam logic [7:0] BURST_BEATS = 8'(BEATS_PER_BURST);

  logic [7:0] reserved_r;
  logic [7:0] in_flight_r;
  logic [7:0] reserved_nxt_s;
  logic [7:0] in_flight_nxt_s;
  logic       pop_ok_s;
  logic       beat_ok_s;

  // Next counter values; an illegal decrement is dropped and flagged instead.
  always_comb begin
    pop_ok_s        = rd_beat_pop && (reserved_r != 8'd0);
    beat_ok_s       = app_rd_data_valid && (in_flight_r != 8'd0);
    underflow_err   = (rd_beat_pop && (reserved_r == 8'd0)) ||
                      (app_rd_data_valid && (in_flight_r == 8'd0));
    reserved_nxt_s  = reserved_r + (rd_accept ? BURST_BEATS : 8'd0) - (pop_ok_s ? 8'd1 : 8'd0);
    in_flight_nxt_s = in_flight_r + (rd_accept ? BURST_BEATS : 8'd0) - (beat_ok_s ? 8'd1 : 8'd0);
  end

  // Counter and registered credit output.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      reserved_r   <= 8'd0;
      in_flight_r  <= 8'd0;
      credit_avail <= CREDIT_MAX;
    end else begin
      reserved_r   <= reserved_nxt_s;
      in_flight_r  <= in_flight_nxt_s;
      credit_avail <= CREDIT_MAX - reserved_nxt_s;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the MIG user port between the coefficient write and read
// requesters, one BL8 command at a time, with read credit flow control.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 27,
  parameter int APP_DATA_WIDTH  = 256,
  parameter int RD_CREDITS      = 32,
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic                        dram_clk,
  input  logic                        reset_n,
  input  logic                        wr_req,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [2*APP_DATA_WIDTH-1:0] wr_data,
  output logic                        wr_ack,
  input  logic                        rd_req,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        rd_ack,
  input  logic                        rd_beat_pop,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic                        app_rd_data_valid,
  output logic                        app_en,
  output logic [2:0]                  app_cmd,
  output logic [ADDR_WIDTH-1:0]       app_addr,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [7:0]                  rd_credit_avail,
  output logic                        busy,
  output logic                        error
);

  localparam logic [7:0] STARVE_MAX = 8'(WR_STARVE_LIMIT);

  arb_state_t                state_r;
  arb_state_t                state_d;
  logic [7:0]                starve_r;
  logic [APP_DATA_WIDTH-1:0] wr_hi_r;
  logic                      rd_elig_s;
  logic                      starve_full_s;
  logic                      grant_rd_s;
  logic                      grant_wr_s;
  logic                      rd_accept_s;
  logic                      wr_accept_s;
  logic                      err_s;

  dram_arbiter_credit #(.RD_CREDITS(RD_CREDITS)) u_credit (
    .dram_clk          (dram_clk),
    .reset_n           (reset_n),
    .rd_accept         (rd_accept_s),
    .rd_beat_pop       (rd_beat_pop),
    .app_rd_data_valid (app_rd_data_valid),
    .credit_avail      (rd_credit_avail),
    .underflow_err     (err_s)
  );

  assign rd_elig_s     = rd_req && (rd_credit_avail >= 8'(BEATS_PER_BURST));
  assign starve_full_s = (starve_r == STARVE_MAX);

  // Next-state and grant/accept decode; a counter underflow overrides everything.
  always_comb begin
    state_d     = state_r;
    grant_rd_s  = 1'b0;
    grant_wr_s  = 1'b0;
    rd_accept_s = 1'b0;
    wr_accept_s = 1'b0;
    if (err_s) begin
      state_d = ST_ERROR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_req && (starve_full_s || !rd_elig_s)) begin
            grant_wr_s = 1'b1;
            state_d    = ST_WR_CMD;
          end else if (rd_elig_s) begin
            grant_rd_s = 1'b1;
            state_d    = ST_RD_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (app_rdy) begin
            rd_accept_s = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RD_CMD;
          end
        end
        ST_WR_CMD: begin
          if (app_rdy) begin
            wr_accept_s = 1'b1;
            state_d     = ST_WR_BEAT0;
          end else begin
            state_d = ST_WR_CMD;
          end
        end
        ST_WR_BEAT0: state_d = app_wdf_rdy ? ST_WR_BEAT1 : ST_WR_BEAT0;
        ST_WR_BEAT1: state_d = app_wdf_rdy ? ST_IDLE : ST_WR_BEAT1;
        ST_ERROR:    state_d = ST_ERROR;
        default:     state_d = ST_ERROR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_d;
  end

  // Consecutive read grants taken while a write was waiting.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n)                  starve_r <= 8'd0;
    else if (grant_wr_s)           starve_r <= 8'd0;
    else if (grant_rd_s && wr_req) starve_r <= sat_inc8(starve_r, STARVE_MAX);
    else                           starve_r <= starve_r;
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      app_en       <= 1'b0;
      app_cmd      <= APP_CMD_WRITE;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_wdf_data <= '0;
      wr_hi_r      <= '0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      app_en       <= (state_d == ST_RD_CMD) || (state_d == ST_WR_CMD);
      app_wdf_wren <= (state_d == ST_WR_BEAT0) || (state_d == ST_WR_BEAT1);
      app_wdf_end  <= (state_d == ST_WR_BEAT1);
      wr_ack       <= wr_accept_s;
      rd_ack       <= rd_accept_s;
      busy         <= (state_d != ST_IDLE);
      error        <= (state_d == ST_ERROR);
      if (grant_rd_s) begin
        app_cmd  <= APP_CMD_READ;
        app_addr <= rd_addr;
      end else if (grant_wr_s) begin
        app_cmd  <= APP_CMD_WRITE;
        app_addr <= wr_addr;
      end
      // wr_data is only guaranteed until wr_ack, so capture both halves at accept.
      if (wr_accept_s) begin
        app_wdf_data <= wr_data[APP_DATA_WIDTH-1:0];
        wr_hi_r      <= wr_data[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH];
      end else if ((state_r == ST_WR_BEAT0) && (state_d == ST_WR_BEAT1)) begin
        app_wdf_data <= wr_hi_r;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_dram_arbiter;

  localparam int AW  = 27;
  localparam int DW  = 256;
  localparam int RDC = 32;
  localparam int SL  = 4;

  logic          dram_clk = 1'b0;
  logic          reset_n  = 1'b1;
  logic          wr_req, rd_req, rd_beat_pop, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [AW-1:0] wr_addr, rd_addr, app_addr;
  logic [2*DW-1:0] wr_data;
  logic          wr_ack, rd_ack, app_en, app_wdf_wren, app_wdf_end, busy, error;
  logic [2:0]    app_cmd;
  logic [DW-1:0] app_wdf_data;
  logic [7:0]    rd_credit_avail;

  int checks   = 0;
  int failures = 0;

  always #5 dram_clk = ~dram_clk;

  dram_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .RD_CREDITS(RDC), .WR_STARVE_LIMIT(SL)) dut (
    .dram_clk(dram_clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_beat_pop(rd_beat_pop),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .rd_credit_avail(rd_credit_avail), .busy(busy), .error(error)
  );

  // inputs {rd_req, wr_req, app_rdy, app_wdf_rdy, rd_beat_pop, app_rd_data_valid}
  // exp    {app_en, app_cmd[2:0], rd_ack, wr_ack, wren, wdf_end, busy, error, credit[7:0]}
  // dsel   0: data not checked, 1: low half of wr_data, 2: high half
  typedef struct packed {
    logic [5:0]  in;
    logic [1:0]  dsel;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge dram_clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] in);
    {rd_req, wr_req, app_rdy, app_wdf_rdy, rd_beat_pop, app_rd_data_valid} = in;
  endtask

  function automatic logic [17:0] obs();
    return {app_en, app_cmd, rd_ack, wr_ack, app_wdf_wren, app_wdf_end, busy, error, rd_credit_avail};
  endfunction

  function automatic vec_t row(input logic [5:0] in, input logic [1:0] dsel, input logic en,
                               input logic [2:0] cmd, input logic ra, input logic wa,
                               input logic wren, input logic wend, input logic bsy,
                               input logic [7:0] cr);
    vec_t v;
    v.in   = in;
    v.dsel = dsel;
    v.exp  = {en, cmd, ra, wa, wren, wend, bsy, 1'b0, cr};
    return v;
  endfunction

  // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
  task automatic do_reset();
    drive(6'b000000);
    reset_n = 1'b0;
    #2;
    check("reset_outputs", 256'(obs()), 256'({10'b0, 8'(RDC)}));
    check("reset_app_addr", 256'(app_addr), 256'd0);
    check("reset_wdf_data", 256'(app_wdf_data), 256'd0);
    @(negedge dram_clk);
    reset_n = 1'b1;
    tick();
  endtask

  logic [17:0]   act_v, req_v;
  logic [9:0]    seq_got, seq_exp;
  logic          en_seen, err_all, rd_acc, wr_acc, en_pre;
  logic [DW-1:0] exp_d;
  logic [DW-1:0] beat_q[$];
  int            n, reserved_m, inflight_m, reserved_pre, rd_wait, wr_wait, max_wait;
  int            rd_cnt, wr_cnt, consec_rd, max_consec;

  initial begin
    wr_addr = 27'h0123456;
    rd_addr = 27'h7654321;
    for (int k = 0; k < 16; k++) wr_data[k*32 +: 32] = 32'hA5000000 + 32'(k);
    drive(6'b000000);

    // single read with one stalled cycle, then data return and pops
    tbl[0]  = row(6'b100000, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd32);
    tbl[1]  = row(6'b100000, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd32);
    tbl[2]  = row(6'b101000, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
    tbl[3]  = row(6'b000001, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
    tbl[4]  = row(6'b000001, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
    tbl[5]  = row(6'b000010, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd31);
    tbl[6]  = row(6'b000010, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32);
    // single write, app_wdf_rdy low for three cycles on beat 1
    tbl[7]  = row(6'b011100, 2'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd32);
    tbl[8]  = row(6'b011100, 2'd1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd32);
    tbl[9]  = row(6'b001100, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd32);
    tbl[10] = row(6'b001000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd32);
    tbl[11] = row(6'b001000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd32);
    tbl[12] = row(6'b001000, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd32);
    tbl[13] = row(6'b001100, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32);
    // two reads; the second accept coincides with a pop (net -1 credit)
    tbl[14] = row(6'b101000, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd32);
    tbl[15] = row(6'b101000, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
    tbl[16] = row(6'b101000, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd30);
    tbl[17] = row(6'b001010, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd29);
    tbl[18] = row(6'b000011, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
    tbl[19] = row(6'b000011, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd31);
    tbl[20] = row(6'b000011, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32);
    tbl[21] = row(6'b000001, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].in);
      tick();
      act_v = obs();
      req_v = tbl[i].exp;
      if (!req_v[17]) begin
        act_v[16:14] = 3'b000;
        req_v[16:14] = 3'b000;
      end
      check($sformatf("vec%0d", i), 256'(act_v), 256'(req_v));
      if (tbl[i].dsel == 2'd1) check($sformatf("vec%0d_data", i), 256'(app_wdf_data), 256'(wr_data[DW-1:0]));
      if (tbl[i].dsel == 2'd2) check($sformatf("vec%0d_data", i), 256'(app_wdf_data), 256'(wr_data[2*DW-1:DW]));
    end

    // credit exhaustion: 16 reads without pops, then release credits one at a time
    do_reset();
    drive(6'b101000);
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      tick();
      if (rd_ack) n++;
    end
    check("exhaust_acks", 256'(n), 256'd16);
    check("exhaust_credit", 256'(rd_credit_avail), 256'd0);
    en_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); en_seen |= app_en; end
    check("blocked_at_0", 256'(en_seen), 256'd0);
    drive(6'b101010); tick(); drive(6'b101000);
    check("credit_after_pop1", 256'(rd_credit_avail), 256'd1);
    en_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); en_seen |= app_en; end
    check("blocked_at_1", 256'(en_seen), 256'd0);
    drive(6'b101010); tick(); drive(6'b101000);
    check("credit_after_pop2", 256'({app_en, rd_credit_avail}), 256'({1'b0, 8'd2}));
    tick();
    check("granted_at_2", 256'({app_en, app_cmd}), 256'(4'b1001));

    // starvation: both requesters held, expect 4 reads then 1 write, repeating
    do_reset();
    drive(6'b111100);
    n = 0;
    seq_got = '0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      tick();
      if (app_en) begin seq_got[n] = (app_cmd == 3'b001); n++; end
    end
    for (int k = 0; k < 10; k++) seq_exp[k] = ((k % (SL + 1)) != SL);
    check("starve_cmds", 256'(n), 256'd10);
    check("starve_order", 256'(seq_got), 256'(seq_exp));

    // read data with nothing outstanding: sticky error, no commands until reset
    do_reset();
    drive(6'b000001); tick(); drive(6'b111100);
    check("err_set", 256'({error, busy, app_en}), 256'(3'b110));
    en_seen = 1'b0;
    err_all = 1'b1;
    for (int c = 0; c < 6; c++) begin tick(); en_seen |= app_en | app_wdf_wren; err_all &= error; end
    check("err_sticky", 256'(err_all), 256'd1);
    check("err_no_cmd", 256'(en_seen), 256'd0);
    do_reset();
    check("err_cleared", 256'({error, busy}), 256'd0);
    drive(6'b000010); tick(); drive(6'b000000);
    check("pop_underflow_err", 256'(error), 256'd1);

    // randomized traffic against a transaction-level model
    do_reset();
    reserved_m = 0; inflight_m = 0; rd_wait = 0; wr_wait = 0; max_wait = 0;
    rd_cnt = 0; wr_cnt = 0; consec_rd = 0; max_consec = 0;
    beat_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!rd_req && $urandom_range(0, 3) == 0) begin rd_req = 1'b1; rd_addr = 27'($urandom); end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = 27'($urandom);
        for (int k = 0; k < 16; k++) wr_data[k*32 +: 32] = $urandom;
      end
      app_rdy           = ($urandom_range(0, 9) < 7);
      app_wdf_rdy       = ($urandom_range(0, 9) < 7);
      rd_beat_pop       = (reserved_m > 0) && ($urandom_range(0, 1) == 1);
      app_rd_data_valid = (inflight_m > 0) && ($urandom_range(0, 1) == 1);

      rd_acc = app_en && (app_cmd == 3'b001) && app_rdy;
      wr_acc = app_en && (app_cmd == 3'b000) && app_rdy;
      en_pre = app_en;
      if (app_wdf_wren && app_wdf_rdy) begin
        if (beat_q.size() == 0) begin
          check("rnd_beat_unexpected", 256'd1, 256'd0);
        end else begin
          exp_d = beat_q.pop_front();
          check("rnd_beat_data", 256'(app_wdf_data), 256'(exp_d));
          check("rnd_beat_end", 256'(app_wdf_end), 256'((beat_q.size() % 2) == 0));
        end
      end
      if (rd_acc) check("rnd_rd_addr", 256'(app_addr), 256'(rd_addr));
      if (wr_acc) begin
        check("rnd_wr_addr", 256'(app_addr), 256'(wr_addr));
        beat_q.push_back(wr_data[DW-1:0]);
        beat_q.push_back(wr_data[2*DW-1:DW]);
      end

      tick();

      check("rnd_rd_ack", 256'(rd_ack), 256'(rd_acc));
      check("rnd_wr_ack", 256'(wr_ack), 256'(wr_acc));
      if (rd_acc || wr_acc) check("rnd_bubble", 256'(app_en), 256'd0);
      reserved_pre = reserved_m;
      reserved_m   = reserved_m + (rd_acc ? 2 : 0) - (rd_beat_pop ? 1 : 0);
      inflight_m   = inflight_m + (rd_acc ? 2 : 0) - (app_rd_data_valid ? 1 : 0);
      check("rnd_credit", 256'(rd_credit_avail), 256'(RDC - reserved_m));
      check("rnd_error", 256'(error), 256'd0);
      if (app_en && !en_pre && (app_cmd == 3'b001))
        check("rnd_rd_eligible", 256'((RDC - reserved_pre) >= 2), 256'd1);

      if (rd_acc) begin
        consec_rd = wr_req ? consec_rd + 1 : 0;
        if (consec_rd > max_consec) max_consec = consec_rd;
      end
      if (wr_acc) consec_rd = 0;
      if (rd_req) rd_wait++;
      if (wr_req) wr_wait++;
      if (rd_wait > max_wait) max_wait = rd_wait;
      if (wr_wait > max_wait) max_wait = wr_wait;
      if (rd_acc) begin rd_req = 1'b0; rd_cnt++; rd_wait = 0; end
      if (wr_acc) begin wr_req = 1'b0; wr_cnt++; wr_wait = 0; end
    end
    check("rnd_rd_progress", 256'(rd_cnt >= 50), 256'd1);
    check("rnd_wr_progress", 256'(wr_cnt >= 50), 256'd1);
    check("rnd_max_wait", 256'(max_wait <= 200), 256'd1);
    check("rnd_starve_bound", 256'(max_consec <= SL + 1), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single MIG user port (app_* interface) between a coefficient write requester (PC-loaded coefficients) and a coefficient read requester (per-frame pixel-coefficient prefetch). Grants one BL8 command at a time, sequences the two-beat write data phase, and tracks read beats in flight against a credit budget so the downstream pixel-coefficient FIFO can never overflow. Sits directly between the frame-processing application logic and the MIG user interface in the dram_clk domain.

## Interface

- ADDR_WIDTH, 27: MIG app_addr width
- APP_DATA_WIDTH, 256: one MIG data beat
- RD_CREDITS, 32: beats of free space in the downstream coefficient FIFO; even, at most 255
- WR_STARVE_LIMIT, 4: consecutive read grants allowed while a write waits

- dram_clk  in  1  MIG user clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request; wr_addr and wr_data held stable until wr_ack
- wr_addr  in  ADDR_WIDTH  write burst address
- wr_data  in  2*APP_DATA_WIDTH  burst data; low half is beat 0
- wr_ack  out  1  one-cycle pulse when write command accepted by MIG
- rd_req  in  1  read request; rd_addr held stable until rd_ack
- rd_addr  in  ADDR_WIDTH  read burst address
- rd_ack  out  1  one-cycle pulse when read command accepted
- rd_beat_pop  in  1  consumer removed one beat from the coefficient FIFO
- app_rdy, app_wdf_rdy, app_rd_data_valid  in  1 each  MIG handshakes
- app_en  out  1  command valid
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  ADDR_WIDTH  command address
- app_wdf_wren, app_wdf_end  out  1 each  write data valid / last beat
- app_wdf_data  out  APP_DATA_WIDTH  write beat
- rd_credit_avail  out  8  free beats remaining
- busy  out  1  state != IDLE
- error  out  1  sticky protocol error

## Operation

- States: IDLE, RD_CMD, WR_CMD, WR_BEAT0, WR_BEAT1, ERROR.
- IDLE grant (one per cycle): read eligible if rd_req && rd_credit_avail >= 2. If write pending and starve_cnt == WR_STARVE_LIMIT, grant write; else eligible read wins; else write if wr_req.
- starve_cnt: +1 on every read grant while wr_req is high, saturating at WR_STARVE_LIMIT; cleared on write grant.
- RD_CMD: app_en=1, app_cmd=001, app_addr=rd_addr; on app_rdy: rd_ack pulse, reserve 2 credits, in_flight += 2, go IDLE.
- WR_CMD: app_en=1, app_cmd=000, app_addr=wr_addr; on app_rdy: wr_ack pulse, latch wr_data, go WR_BEAT0.
- WR_BEAT0: app_wdf_wren=1, app_wdf_end=0, low half; on app_wdf_rdy go WR_BEAT1.
- WR_BEAT1: app_wdf_wren=1, app_wdf_end=1, high half; on app_wdf_rdy go IDLE.
- Credits: rd_credit_avail = RD_CREDITS - reserved; reserved +2 per accepted read, -1 per rd_beat_pop. Both in one cycle: net +1 reserved.
- in_flight: -1 per app_rd_data_valid beat; reads/writes interleave freely because read data return is tracked only by counters.
- Error (go to ERROR, sticky, all app_* strobes low, only reset exits): app_rd_data_valid with in_flight == 0; rd_beat_pop with reserved == 0.

## Timing

- Reset values: app_en 0, app_cmd 000, app_addr 0, app_wdf_wren 0, app_wdf_end 0, app_wdf_data 0, wr_ack 0, rd_ack 0, busy 0, error 0, rd_credit_avail RD_CREDITS; counters 0.
- All outputs registered. Request seen in IDLE at cycle N -> app_en high at N+1; accept at first edge with app_en && app_rdy; ack pulses the cycle after accept.
- app_en/app_cmd/app_addr held constant while app_rdy low; no back-to-back command without passing IDLE (one bubble minimum).
- Minimum write: 4 cycles from grant (cmd, beat0, beat1, back to IDLE) with rdy signals high.
- Reset asserted mid-burst: outputs go to reset values asynchronously; partial write burst is abandoned (MIG is reset alongside).
- Requester dropping req before ack is undefined; not checked.

## Structure

- Shared package: app_cmd encodings, state encoding, BEATS_PER_BURST = 2.
- One sub-module natural: dram_arbiter_credit (reserved/in_flight counters, credit_avail, underflow error), instantiated once.

## Test plan

- Single read, app_rdy high: rd_req -> app_en/app_cmd=001 one cycle, rd_ack, rd_credit_avail 32 -> 30; two app_rd_data_valid beats -> in_flight 0.
- Single write, app_wdf_rdy stalled 3 cycles on beat1: beats 0 then 1 with app_wdf_end only on beat1, data halves in order, wr_ack once.
- Credit exhaustion: 16 reads with no pops -> credit 0, 17th rd_req not granted; one pop -> credit 1, still blocked; second pop -> granted.
- Starvation: rd_req and wr_req held high, credits ample -> exactly 4 read grants then 1 write grant, repeating.
- Simultaneous read accept and rd_beat_pop -> credit drops by exactly 1.
- app_rd_data_valid with nothing outstanding -> error high, stays high, no further app_en until reset_n pulse.
